// File: rtl/explosion_pkg.sv
// Shared constants, types and helpers for the explosion scheduler slice.
package explosion_pkg;

  localparam int NUM_ENEMIES = 16;
  localparam int NUM_SLOTS   = 2;
  localparam int FRAMES      = 4;
  localparam int FRAME_HOLD  = 8;
  localparam int FRAME_W     = 2;
  localparam int ENEMY_ID_W  = $clog2(NUM_ENEMIES);
  // A hold of one cycle still needs a one-bit counter to stay legal.
  localparam int HOLD_W      = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  typedef enum logic {
    SLOT_IDLE = 1'b0,
    SLOT_RUN  = 1'b1
  } slot_state_t;

  typedef struct packed {
    logic                  active;
    logic [FRAME_W-1:0]    frame;
    logic [ENEMY_ID_W-1:0] id;
  } slot_status_t;

  // One-hot decode of an enemy id into a requester-wide mask.
  function automatic logic [NUM_ENEMIES-1:0] id_onehot(input logic [ENEMY_ID_W-1:0] id);
    logic [NUM_ENEMIES-1:0] one;
    one = {{(NUM_ENEMIES-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/explosion_scheduler_if.sv
// Hit-request / slot-status bundle between collision logic, renderer and scheduler.
interface explosion_scheduler_if;

  logic [explosion_pkg::NUM_ENEMIES-1:0]                          hit_req;
  logic                                                           clear;
  logic [explosion_pkg::NUM_SLOTS-1:0]                            slot_active;
  logic [explosion_pkg::NUM_SLOTS*explosion_pkg::FRAME_W-1:0]     slot_frame;
  logic [explosion_pkg::NUM_SLOTS*explosion_pkg::ENEMY_ID_W-1:0]  slot_enemy_id;
  logic [explosion_pkg::NUM_SLOTS-1:0]                            slot_done;
  logic [explosion_pkg::NUM_ENEMIES-1:0]                          pending;
  logic                                                           busy;

  modport master (
    output hit_req, clear,
    input  slot_active, slot_frame, slot_enemy_id, slot_done, pending, busy
  );

  modport slave (
    input  hit_req, clear,
    output slot_active, slot_frame, slot_enemy_id, slot_done, pending, busy
  );

endinterface

// File: rtl/explosion_slot.sv
// One explosion animator: IDLE/RUN FSM stepping through the frames with a hold counter.
module explosion_slot
  import explosion_pkg::*;
(
  input  logic                  clkdiv2,
  input  logic                  Reset,
  input  logic                  clear_i,
  input  logic                  grant_i,
  input  logic [ENEMY_ID_W-1:0] grant_id_i,
  output slot_status_t          status_o,
  output logic                  done_o
);

  localparam logic [HOLD_W-1:0]  LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(FRAMES - 1);

  slot_state_t           state_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [FRAME_W-1:0]    frame_q;
  logic [ENEMY_ID_W-1:0] id_q;
  logic                  done_q;

  // Slot FSM: start on grant, advance a frame every FRAME_HOLD cycles, pulse done after the last.
  always_ff @(posedge clkdiv2 or posedge Reset) begin
    if (Reset) begin
      state_q <= SLOT_IDLE;
      hold_q  <= {HOLD_W{1'b0}};
      frame_q <= {FRAME_W{1'b0}};
      id_q    <= {ENEMY_ID_W{1'b0}};
      done_q  <= 1'b0;
    end else if (clear_i) begin
      state_q <= SLOT_IDLE;
      hold_q  <= {HOLD_W{1'b0}};
      frame_q <= {FRAME_W{1'b0}};
      id_q    <= {ENEMY_ID_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        SLOT_IDLE: begin
          if (grant_i) begin
            state_q <= SLOT_RUN;
            hold_q  <= {HOLD_W{1'b0}};
            frame_q <= {FRAME_W{1'b0}};
            id_q    <= grant_id_i;
          end
        end
        SLOT_RUN: begin
          if (hold_q == LAST_HOLD) begin
            hold_q <= {HOLD_W{1'b0}};
            if (frame_q == LAST_FRAME) begin
              state_q <= SLOT_IDLE;
              frame_q <= {FRAME_W{1'b0}};
              done_q  <= 1'b1;
            end else begin
              frame_q <= frame_q + FRAME_W'(1);
            end
          end else begin
            hold_q <= hold_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q <= SLOT_IDLE;
          hold_q  <= {HOLD_W{1'b0}};
          frame_q <= {FRAME_W{1'b0}};
        end
      endcase
    end
  end

  assign status_o.active = (state_q == SLOT_RUN);
  assign status_o.frame  = frame_q;
  assign status_o.id     = id_q;
  assign done_o          = done_q;

endmodule

// File: rtl/explosion_scheduler.sv
// Pending-hit bitmap plus round-robin arbiter feeding a small pool of explosion slots.
module explosion_scheduler
  import explosion_pkg::*;
(
  input  logic                  clkdiv2,
  input  logic                  Reset,
  explosion_scheduler_if.slave  bus
);

  slot_status_t            status_s [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    done_s;
  logic [NUM_SLOTS-1:0]    slot_grant_s;
  logic [NUM_ENEMIES-1:0]  pending_q, pending_d;
  logic [NUM_ENEMIES-1:0]  active_mask_s, grant_mask_s;
  logic [ENEMY_ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ENEMY_ID_W-1:0]   winner_s;
  logic                    win_found_s, free_found_s, grant_valid_s;

  // Circular search of pending from rr_ptr, and pick of the lowest idle slot.
  always_comb begin
    logic [ENEMY_ID_W-1:0] idx_v;
    win_found_s  = 1'b0;
    winner_s     = rr_ptr_q;
    free_found_s = 1'b0;
    slot_grant_s = {NUM_SLOTS{1'b0}};
    for (int k = 0; k < NUM_ENEMIES; k++) begin
      idx_v = rr_ptr_q + ENEMY_ID_W'(k);
      if (!win_found_s && pending_q[idx_v]) begin
        win_found_s = 1'b1;
        winner_s    = idx_v;
      end else begin
        win_found_s = win_found_s;
      end
    end
    grant_valid_s = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!free_found_s && !status_s[s].active) begin
        free_found_s = 1'b1;
        if (win_found_s && !bus.clear) begin
          slot_grant_s[s] = 1'b1;
          grant_valid_s   = 1'b1;
        end else begin
          slot_grant_s[s] = 1'b0;
        end
      end else begin
        slot_grant_s[s] = 1'b0;
      end
    end
  end

  // Next pending bitmap and pointer; ids already animating are not re-queued, grant beats set.
  always_comb begin
    active_mask_s = {NUM_ENEMIES{1'b0}};
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (status_s[s].active) begin
        active_mask_s = active_mask_s | id_onehot(status_s[s].id);
      end else begin
        active_mask_s = active_mask_s;
      end
    end
    if (grant_valid_s) begin
      grant_mask_s = id_onehot(winner_s);
      rr_ptr_d     = winner_s + ENEMY_ID_W'(1);
    end else begin
      grant_mask_s = {NUM_ENEMIES{1'b0}};
      rr_ptr_d     = rr_ptr_q;
    end
    if (bus.clear) begin
      pending_d = {NUM_ENEMIES{1'b0}};
      rr_ptr_d  = {ENEMY_ID_W{1'b0}};
    end else begin
      pending_d = (pending_q | (bus.hit_req & ~active_mask_s)) & ~grant_mask_s;
    end
  end

  // Pending bitmap and round-robin pointer registers.
  always_ff @(posedge clkdiv2 or posedge Reset) begin
    if (Reset) begin
      pending_q <= {NUM_ENEMIES{1'b0}};
      rr_ptr_q  <= {ENEMY_ID_W{1'b0}};
    end else begin
      pending_q <= pending_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    explosion_slot u_slot (
      .clkdiv2    (clkdiv2),
      .Reset      (Reset),
      .clear_i    (bus.clear),
      .grant_i    (slot_grant_s[g]),
      .grant_id_i (winner_s),
      .status_o   (status_s[g]),
      .done_o     (done_s[g])
    );
  end

  logic [NUM_SLOTS-1:0]            active_s;
  logic [NUM_SLOTS*FRAME_W-1:0]    frame_s;
  logic [NUM_SLOTS*ENEMY_ID_W-1:0] id_s;

  // Flatten per-slot status into the renderer-facing buses.
  always_comb begin
    active_s = {NUM_SLOTS{1'b0}};
    frame_s  = {(NUM_SLOTS*FRAME_W){1'b0}};
    id_s     = {(NUM_SLOTS*ENEMY_ID_W){1'b0}};
    for (int s = 0; s < NUM_SLOTS; s++) begin
      active_s[s]                       = status_s[s].active;
      frame_s[s*FRAME_W +: FRAME_W]     = status_s[s].frame;
      id_s[s*ENEMY_ID_W +: ENEMY_ID_W]  = status_s[s].id;
    end
  end

  assign bus.slot_active   = active_s;
  assign bus.slot_frame    = frame_s;
  assign bus.slot_enemy_id = id_s;
  assign bus.slot_done     = done_s;
  assign bus.pending       = pending_q;
  assign bus.busy          = (|active_s) | (|pending_q);

endmodule

// File: tb/tb_explosion_scheduler.sv
// Self-checking bench: directed scenarios plus random hits against a frame-time model.
module tb_explosion_scheduler;

  localparam int NE   = 16;
  localparam int NS   = 2;
  localparam int FR   = 4;
  localparam int FH   = 8;
  localparam int LIFE = FR * FH;

  logic clkdiv2 = 1'b0;
  logic Reset;

  always #5 clkdiv2 = ~clkdiv2;

  explosion_scheduler_if bus();

  explosion_scheduler dut (
    .clkdiv2 (clkdiv2),
    .Reset   (Reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each slot tracks cycles elapsed since its grant.
  bit          m_act  [NS];
  int          m_age  [NS];
  int          m_id   [NS];
  bit          m_done [NS];
  bit [NE-1:0] m_pend;
  int          m_rr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_act[s] = 1'b0; m_age[s] = 0; m_id[s] = 0; m_done[s] = 1'b0;
    end
    m_pend = '0;
    m_rr   = 0;
  endtask

  task automatic model_step(input bit [NE-1:0] hit, input bit clr);
    int          win;
    int          free;
    bit [NE-1:0] amask;
    bit [NE-1:0] gbit;
    if (clr) begin
      model_reset();
      return;
    end
    win = -1;
    for (int k = 0; k < NE; k++)
      if (win < 0 && m_pend[(m_rr + k) % NE]) win = (m_rr + k) % NE;
    free = -1;
    amask = '0;
    for (int s = 0; s < NS; s++) begin
      if (!m_act[s] && free < 0) free = s;
      if (m_act[s]) amask[m_id[s]] = 1'b1;
    end
    for (int s = 0; s < NS; s++) begin
      m_done[s] = 1'b0;
      if (m_act[s]) begin
        m_age[s]++;
        if (m_age[s] == LIFE) begin
          m_act[s]  = 1'b0;
          m_done[s] = 1'b1;
        end
      end
    end
    gbit = '0;
    if (win >= 0 && free >= 0) begin
      m_act[free] = 1'b1;
      m_age[free] = 0;
      m_id[free]  = win;
      m_rr        = (win + 1) % NE;
      gbit[win]   = 1'b1;
    end
    m_pend = (m_pend | (hit & ~amask)) & ~gbit;
  endtask

  task automatic compare_all();
    logic [NS-1:0]   ea, ed;
    logic [NS*2-1:0] ef;
    logic [NS*4-1:0] ei;
    for (int s = 0; s < NS; s++) begin
      ea[s]       = m_act[s];
      ed[s]       = m_done[s];
      ef[2*s +: 2] = m_act[s] ? 2'(m_age[s] / FH) : 2'd0;
      ei[4*s +: 4] = 4'(m_id[s]);
    end
    check("slot_active",   32'(bus.slot_active),   32'(ea));
    check("slot_frame",    32'(bus.slot_frame),    32'(ef));
    check("slot_enemy_id", 32'(bus.slot_enemy_id), 32'(ei));
    check("slot_done",     32'(bus.slot_done),     32'(ed));
    check("pending",       32'(bus.pending),       32'(m_pend));
    check("busy",          32'(bus.busy),          32'((|ea) | (|m_pend)));
  endtask

  task automatic step(input logic [NE-1:0] hit, input logic clr);
    bus.hit_req = hit;
    bus.clear   = clr;
    @(posedge clkdiv2);
    model_step(hit, clr);
    #1;
    bus.hit_req = '0;
    bus.clear   = 1'b0;
    compare_all();
  endtask

  initial begin
    Reset       = 1'b1;
    bus.hit_req = '0;
    bus.clear   = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clkdiv2);
    Reset = 1'b0;

    // Single hit on enemy 4.
    step(16'h0010, 1'b0);
    check("single_pending", 32'(bus.pending), 32'h0010);
    step(16'h0000, 1'b0);
    check("single_id", 32'(bus.slot_enemy_id[3:0]), 32'd4);
    check("single_active", 32'(bus.slot_active), 32'h1);
    // Re-hit of the active id must not queue.
    step(16'h0010, 1'b0);
    check("dup_pending", 32'(bus.pending), 32'h0);
    repeat (30) step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    check("single_done", 32'(bus.slot_done), 32'h1);
    repeat (3) step(16'h0000, 1'b0);

    // Async reset mid-frame.
    step(16'h0100, 1'b0);
    repeat (12) step(16'h0000, 1'b0);
    @(negedge clkdiv2);
    Reset = 1'b1;
    #1;
    model_reset();
    check("areset_active", 32'(bus.slot_active), 32'h0);
    check("areset_frame",  32'(bus.slot_frame),  32'h0);
    check("areset_id",     32'(bus.slot_enemy_id), 32'h0);
    check("areset_pend",   32'(bus.pending),     32'h0);
    @(negedge clkdiv2);
    Reset = 1'b0;
    step(16'h8000, 1'b0);
    step(16'h0000, 1'b0);
    check("post_reset_id", 32'(bus.slot_enemy_id[3:0]), 32'd15);
    repeat (40) step(16'h0000, 1'b0);

    // Three simultaneous hits with rr_ptr back at 0.
    step(16'h0007, 1'b0);
    for (int e = 1; e <= 68; e++) begin
      step(16'h0000, 1'b0);
      if (e == 1)  check("three_e1_id", 32'(bus.slot_enemy_id[3:0]), 32'd0);
      if (e == 2)  check("three_e2_id", 32'(bus.slot_enemy_id[7:4]), 32'd1);
      if (e == 34) check("three_e34_id", 32'(bus.slot_enemy_id[3:0]), 32'd2);
      if (e == 65) check("three_busy65", 32'(bus.busy), 32'h1);
      if (e == 66) check("three_busy66", 32'(bus.busy), 32'h0);
    end

    // Clear with both slots running and enemy 7 waiting.
    step(16'h0003, 1'b0);
    repeat (18) step(16'h0000, 1'b0);
    step(16'h0080, 1'b0);
    check("clear_pre_pend", 32'(bus.pending), 32'h0080);
    step(16'h0200, 1'b1);
    check("clear_done",   32'(bus.slot_done),   32'h0);
    check("clear_active", 32'(bus.slot_active), 32'h0);
    check("clear_pend",   32'(bus.pending),     32'h0);
    repeat (40) step(16'h0000, 1'b0);

    // Randomised traffic, including occasional clear.
    for (int i = 0; i < 3000; i++) begin
      logic [NE-1:0] h;
      logic          c;
      h = ($urandom_range(0, 5) == 0) ? (NE'($urandom) & NE'($urandom)) : '0;
      c = ($urandom_range(0, 199) == 0);
      step(h, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/explosion_scheduler.md
Name: explosion_scheduler

Overview:
- Shares a small pool of explosion animator slots among all enemies.
- Accepts one-cycle hit pulses from collision logic and holds them in a pending bitmap.
- Grants pending hits to free slots using round-robin arbitration.
- Runs each slot through a 4-frame animation and reports per-slot frame, enemy id and completion to the sprite renderer and score logic.

Parameters:
- NUM_ENEMIES, 16, number of requesters (hit_req width); power of two.
- NUM_SLOTS, 2, concurrent explosion animators.
- FRAMES, 4, animation frames per explosion (frame index width = 2).
- FRAME_HOLD, 8, clkdiv2 cycles each frame is displayed; ≥1.

Ports:
- clkdiv2  in  1  animation clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- hit_req  in  NUM_ENEMIES  one-cycle pulse per enemy destroyed.
- clear  in  1  synchronous flush: level change / game over.
- slot_active  out  NUM_SLOTS  slot s is animating.
- slot_frame  out  NUM_SLOTS*2  frame index of slot s, bits [2s+1:2s].
- slot_enemy_id  out  NUM_SLOTS*4  enemy index owned by slot s, bits [4s+3:4s].
- slot_done  out  NUM_SLOTS  one-cycle pulse when slot s finishes its last frame.
- pending  out  NUM_ENEMIES  hits waiting for a slot.
- busy  out  1  OR of slot_active and pending.

Behaviour:
- Reset (async): pending=0, all slots IDLE, slot_active=0, slot_frame=0, slot_enemy_id=0, slot_done=0, rr_ptr=0. The same state is entered from any point mid-animation.
- Pending capture:
  - pending[i] sets on the edge where hit_req[i]=1.
  - pending[i] clears on the edge where it is granted.
  - A hit for an enemy that is already pending, or that is the id of an active slot, is ignored (no double explosion).
  - Set and grant of the same bit on one edge: grant wins and the bit ends clear.
- Arbitration, combinational from registered state:
  - Search pending circularly starting at rr_ptr; the first set bit is the winner.
  - At most one grant per edge, into the lowest-numbered IDLE slot.
  - On grant, rr_ptr ← winner+1 mod NUM_ENEMIES.
  - No grant if no slot is IDLE or pending=0.
- Latency:
  - hit_req at edge t → pending at t.
  - Grant at edge t+1 if a slot is free: slot_active=1, slot_frame=0, slot_enemy_id=winner.
- Slot FSM, per slot:
  - States: IDLE, RUN. Each slot has hold_cnt (width clog2(FRAME_HOLD)) and frame (2 bits).
  - IDLE→RUN on grant; frame=0, hold_cnt=0.
  - RUN: hold_cnt increments each edge. When hold_cnt=FRAME_HOLD-1, hold_cnt←0 and frame←frame+1.
  - RUN with frame=FRAMES-1 and hold_cnt=FRAME_HOLD-1 → IDLE; slot_done[s]=1 for exactly one cycle; slot_active=0 and slot_frame=0 on the same edge.
  - Each explosion therefore lasts exactly FRAMES*FRAME_HOLD cycles of slot_active=1.
  - A slot freed at edge t can be regranted at edge t+1, never at edge t.
- Simultaneous events:
  - Multiple slots may pulse slot_done on the same edge.
  - Multiple hit_req bits may set on the same edge; all are captured.
  - None are lost while pending has room; pending is a bitmap, so it never overflows.
- clear (sync, priority over all except Reset): next edge behaves like reset. No slot_done pulses are emitted, and hit_req asserted in the same cycle is discarded.
- Ids are held stable while a slot is active. slot_enemy_id keeps its last value in IDLE; consumers must qualify it with slot_active.

Decomposition:
- Shared package explosion_pkg:
  - localparams FRAMES, FRAME_HOLD defaults;
  - ENEMY_ID_W = $clog2(NUM_ENEMIES);
  - typedef enum logic {SLOT_IDLE, SLOT_RUN} slot_state_t;
  - typedef struct for slot status (active, frame, id).
- Sub-module explosion_slot: one per slot, holds the IDLE/RUN FSM plus hold/frame counters; instantiated with a generate loop.
- Round-robin arbiter and pending bitmap live in the top.

Test Plan:
- Single hit: hit_req=16'h0010 at edge 0 → pending[4]=1 at edge 0; edge 1 slot0 active, id=4, frame=0. Frames 1/2/3 at edges 9/17/25; slot_done[0] at edge 33; pending=0 throughout.
- Three simultaneous hits, hit_req=16'h0007, rr_ptr=0:
  - edge 1: slot0 gets id 0; edge 2: slot1 gets id 1.
  - id 2 waits in pending and is granted to slot0 at edge 34 (slot0 done at 33).
  - busy stays 1 until edge 66.
- Round-robin fairness: hits on 3 and 12 arrive while both slots are busy and rr_ptr=5 → 12 is granted before 3.
- Duplicate suppression: hit_req[4] is pulsed again while id 4 is active in slot0 → pending[4] stays 0; no second explosion.
- clear at edge 20 with both slots active and pending[7]=1 → next edge: all outputs 0, no slot_done pulse, no later grant for id 7.
- Async Reset asserted mid-frame between edges → outputs 0 immediately. After release, a hit on 15 starts normally with rr_ptr=0.
